ahb2apb_bridge: RTL and testbench

- AHB-Lite slave to APB master bridge, directly upstream of the APB decoder / peripheral stage.
- Converts each AHB NONSEQ/SEQ transfer into one APB SETUP/ACCESS sequence.
- Inserts AHB wait states until the peripheral PREADY arrives.
- Maps PSLVERR and timeouts to the AHB two-cycle ERROR response, and generates PSTRB from HSIZE/HADDR.

---
 rtl/ahb2apb_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ahb2apb_bridge
//  Purpose  : AHB-Lite slave to APB master bridge. Each AHB NONSEQ/SEQ
//             transfer becomes one APB SETUP/ACCESS pair. AHB wait states
//             are inserted until PREADY. PSLVERR, an illegal HSIZE or an
//             ACCESS timeout produce the two-cycle AHB ERROR response.
//  Ports    : clk, rst (sync, active low)
//             AHB  : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN
//                    -> HREADYOUT, HRESP, HRDATA
//             APB  : PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
//                    <- PRDATA, PREADY, PSLVERR
//             All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module ahb2apb_bridge #(
    parameter int TIMEOUT = 16,   // ACCESS cycles before forced error, 0 = never
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADYIN,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    output logic [3:0]        PSTRB,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                hreadyout_q, hreadyout_d;
    logic                hresp_q,     hresp_d;
    logic [31:0]         hrdata_q,    hrdata_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [31:0]         pwdata_q,    pwdata_d;
    logic [3:0]          pstrb_q,     pstrb_d;

    logic                w_xfer_valid;
    logic [3:0]          w_strb;
    logic                w_unused;

    // HTRANS[0] only distinguishes NONSEQ from SEQ, which the bridge treats alike
    assign w_unused     = HTRANS[0];
    assign w_xfer_valid = HSEL & HREADYIN & HTRANS[1];

    // Byte lanes for the incoming transfer; reads never drive strobes
    always_comb begin
        w_strb = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    w_strb = 4'b0001 << HADDR[1:0];
                3'd1:    w_strb = HADDR[1] ? 4'b1100 : 4'b0011;
                3'd2:    w_strb = 4'b1111;
                default: w_strb = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;

        case (state_q)
            // ERR2 is an AHB-ready cycle, so it accepts a new address exactly as IDLE does
            S_IDLE, S_ERR2: begin
                state_d     = S_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                if (w_xfer_valid) begin
                    hreadyout_d = 1'b0;
                    if (HSIZE > 3'd2) begin
                        // Unsupported size: answer with ERROR, never touch the APB side
                        state_d = S_ERR1;
                        hresp_d = 1'b1;
                    end else begin
                        state_d  = S_SETUP;
                        psel_d   = 1'b1;
                        paddr_d  = HADDR;
                        pwrite_d = HWRITE;
                        pwdata_d = HWDATA;
                        pstrb_d  = w_strb;
                    end
                end
            end

            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end

            S_ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    if (PSLVERR) begin
                        state_d = S_ERR1;
                        hresp_d = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        hreadyout_d = 1'b1;
                        hresp_d     = 1'b0;
                        if (!pwrite_q) begin
                            hrdata_d = PRDATA;
                        end
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == C_TO_LAST)) begin
                    // Peripheral never answered: abandon the APB transfer
                    state_d   = S_ERR1;
                    hresp_d   = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ERR1: begin
                state_d     = S_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b1;
            end

            default: begin
                state_d     = S_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb2apb_bridge
//  Purpose  : Directed scoreboard bench for ahb2apb_bridge. The driver queues
//             the expected APB SETUP contents and the expected AHB response
//             (HRESP, HRDATA, wait-state count); a monitor pops and compares
//             whenever the bridge shows a SETUP phase or ends a wait period.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb2apb_bridge;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } apb_exp_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
    } ahb_exp_t;

    logic        clk;
    logic        rst;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_exp_t    apb_q[$];
    ahb_exp_t    ahb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_rdata = 32'h0;

    // APB slave behaviour for the current transfer
    int          sl_delay = 0;
    logic        sl_err   = 1'b0;
    logic [31:0] sl_rdata = 32'h0;
    int          acc_cnt  = 0;

    // Monitor state
    int          mon_waits = 0;
    logic        mon_in    = 1'b0;
    logic        mon_last  = 1'b0;

    ahb2apb_bridge #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // Single-slave bus: the bus-wide ready is the bridge's own ready
    assign HREADYIN = HREADYOUT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // APB slave: answers after sl_delay ACCESS cycles
    initial begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                if (acc_cnt >= sl_delay) begin
                    PREADY  = 1'b1;
                    PSLVERR = sl_err;
                    PRDATA  = sl_rdata;
                end else begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'b0;
                    PRDATA  = 32'hDEAD_BEEF;
                end
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                PRDATA  = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin : monitor
        apb_exp_t a;
        ahb_exp_t h;
        if (rst !== 1'b1) begin
            mon_in    = 1'b0;
            mon_waits = 0;
        end else begin
            if (PSEL === 1'b1 && PENABLE === 1'b0) begin
                chk("apb_setup_expected", 32'(apb_q.size() > 0), 32'd1);
                if (apb_q.size() > 0) begin
                    a = apb_q.pop_front();
                    chk("paddr",  PADDR,         a.addr);
                    chk("pwrite", 32'(PWRITE),   32'(a.wr));
                    chk("pstrb",  32'(PSTRB),    32'(a.strb));
                    chk("pwdata", PWDATA,        a.wdata);
                end
            end
            if (HREADYOUT !== 1'b1) begin
                if (HRESP === 1'b1) begin
                    chk("psel_dropped_on_error", 32'(PSEL), 32'd0);
                end
                mon_in   = 1'b1;
                mon_last = HRESP;
                mon_waits++;
            end else if (mon_in) begin
                chk("ahb_resp_expected", 32'(ahb_q.size() > 0), 32'd1);
                if (ahb_q.size() > 0) begin
                    h = ahb_q.pop_front();
                    chk("hresp",        32'(HRESP),    32'(h.resp));
                    chk("hresp_first",  32'(mon_last), 32'(h.resp));
                    chk("hrdata",       HRDATA,        h.rdata);
                    chk("wait_states",  32'(mon_waits), 32'(h.waits));
                end
                mon_in    = 1'b0;
                mon_waits = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, input int delay, input logic err,
                         input logic [31:0] rdata, input logic [3:0] exp_strb,
                         input int exp_waits, input logic exp_resp, input logic want_resp);
        apb_exp_t a;
        ahb_exp_t h;
        int guard;
        guard = 0;
        while (HREADYOUT !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("issue_ready_timeout", 32'(guard), 32'd0);
        if (size <= 3'd2) begin
            a.addr  = addr;
            a.wr    = wr;
            a.strb  = exp_strb;
            a.wdata = wdata;
            apb_q.push_back(a);
        end
        if (!wr && !exp_resp) model_rdata = rdata;
        if (want_resp) begin
            h.resp  = exp_resp;
            h.rdata = model_rdata;
            h.waits = exp_waits;
            ahb_q.push_back(h);
        end
        sl_delay = delay;
        sl_err   = err;
        sl_rdata = rdata;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        HWDATA = wdata;
        @(posedge clk); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((ahb_q.size() != 0 || HREADYOUT !== 1'b1) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 32'(guard), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        HSEL   = 1'b0;
        HADDR  = 32'h0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HWDATA = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp",     32'(HRESP),     32'd0);
        chk("rst_hrdata",    HRDATA,         32'd0);
        chk("rst_psel",      32'(PSEL),      32'd0);
        chk("rst_penable",   32'(PENABLE),   32'd0);
        chk("rst_pwrite",    32'(PWRITE),    32'd0);
        chk("rst_paddr",     PADDR,          32'd0);
        chk("rst_pwdata",    PWDATA,         32'd0);
        chk("rst_pstrb",     32'(PSTRB),     32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        //     addr          wr    size  wdata          dly   err   rdata          strb     waits resp  want
        issue(32'h0000_03E8, 1'b1, 3'd2, 32'h0000_00A5, 0,    1'b0, 32'h1234_5678, 4'b1111, 2,    1'b0, 1'b1);
        issue(32'h0000_03E8, 1'b0, 3'd2, 32'h0,         3,    1'b0, 32'h0000_005A, 4'b0000, 5,    1'b0, 1'b1);
        issue(32'h0000_03EA, 1'b1, 3'd0, 32'h0011_0000, 0,    1'b0, 32'h1234_5678, 4'b0100, 2,    1'b0, 1'b1);
        issue(32'h0000_03EA, 1'b1, 3'd1, 32'h2222_0000, 0,    1'b0, 32'h1234_5678, 4'b1100, 2,    1'b0, 1'b1);
        issue(32'h0000_03E8, 1'b1, 3'd1, 32'h0000_3333, 1,    1'b0, 32'h1234_5678, 4'b0011, 3,    1'b0, 1'b1);
        issue(32'h0000_03EB, 1'b1, 3'd0, 32'h4400_0000, 0,    1'b0, 32'h1234_5678, 4'b1000, 2,    1'b0, 1'b1);
        // illegal size: ERROR with no APB access
        issue(32'h0000_03E8, 1'b1, 3'd3, 32'h0000_0055, 0,    1'b0, 32'h1234_5678, 4'b0000, 1,    1'b1, 1'b1);
        // slave error
        issue(32'h0000_0100, 1'b1, 3'd2, 32'hCAFE_F00D, 0,    1'b1, 32'h1234_5678, 4'b1111, 3,    1'b1, 1'b1);
        // timeout: SETUP + 16 ACCESS + ERR1
        issue(32'h0000_0200, 1'b0, 3'd2, 32'h0,         1000, 1'b0, 32'h0BAD_0BAD, 4'b0000, 18,   1'b1, 1'b1);
        // back-to-back writes
        issue(32'h0000_03E8, 1'b1, 3'd2, 32'h1111_1111, 0,    1'b0, 32'h1234_5678, 4'b1111, 2,    1'b0, 1'b1);
        issue(32'h0000_03EC, 1'b1, 3'd2, 32'h2222_2222, 0,    1'b0, 32'h1234_5678, 4'b1111, 2,    1'b0, 1'b1);
        // error followed immediately by a read presented in ERR2
        issue(32'h0000_03E8, 1'b0, 3'd3, 32'h0,         0,    1'b0, 32'h1234_5678, 4'b0000, 1,    1'b1, 1'b1);
        issue(32'h0000_03F0, 1'b0, 3'd2, 32'h0,         0,    1'b0, 32'h0000_00C3, 4'b0000, 2,    1'b0, 1'b1);
        drain();

        // Non-valid cycles: BUSY while selected, NONSEQ while unselected
        HSEL   = 1'b1;
        HTRANS = 2'b01;
        HADDR  = 32'h0000_0400;
        repeat (2) begin
            @(negedge clk);
            chk("busy_hreadyout", 32'(HREADYOUT), 32'd1);
            chk("busy_psel",      32'(PSEL),      32'd0);
        end
        @(posedge clk); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b10;
        repeat (2) begin
            @(negedge clk);
            chk("unsel_hreadyout", 32'(HREADYOUT), 32'd1);
            chk("unsel_hresp",     32'(HRESP),     32'd0);
        end
        @(posedge clk); #1;
        HTRANS = 2'b00;

        // Reset during ACCESS aborts the transfer
        issue(32'h0000_0300, 1'b0, 3'd2, 32'h0, 1000, 1'b0, 32'h0000_0099, 4'b0000, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_rdata = 32'h0;
        @(negedge clk);
        chk("abort_psel",      32'(PSEL),      32'd0);
        chk("abort_penable",   32'(PENABLE),   32'd0);
        chk("abort_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("abort_hresp",     32'(HRESP),     32'd0);
        chk("abort_hrdata",    HRDATA,         32'd0);
        @(posedge clk); #1;
        issue(32'h0000_0304, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0000_0077, 4'b0000, 2, 1'b0, 1'b1);
        drain();
        repeat (2) @(posedge clk);

        chk("ahb_queue_empty", 32'(ahb_q.size()), 32'd0);
        chk("apb_queue_empty", 32'(apb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
